// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with oversampled mid-bit sampling and its own
//               tick generator. Define UART_RX_PARITY_EN for 8E1/8O1 framing.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int c_DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int c_TW  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
    localparam int c_OW  = $clog2(OVERSAMPLE);

    localparam logic [c_TW-1:0] c_TICK_MAX = c_TW'(c_DIV - 1);
    localparam logic [c_OW-1:0] c_OS_HALF  = c_OW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OW-1:0] c_OS_LAST  = c_OW'(OVERSAMPLE - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_AFTER_DATA = c_ST_PARITY;
`else
    localparam logic [2:0] c_ST_AFTER_DATA = 3'd4;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_BREAK  = 3'd5;

    logic            r_rx_meta, r_rx_s;
    logic [2:0]      r_state, w_state_nxt;
    logic [c_TW-1:0] r_tick_cnt;
    logic [c_OW-1:0] r_os_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid, r_frame_err;
    logic            w_tick, w_mid;
    logic            w_os_clr, w_os_inc, w_shift, w_bit_clr;
    logic            w_valid_nxt, w_ferr_nxt;
    logic            w_par_fail;

`ifdef UART_RX_PARITY_EN
    logic            r_par_bad, r_parity_err;
    logic            w_par_chk, w_perr_nxt;
    assign w_par_fail = r_par_bad;
    assign parity_err = r_parity_err;
`else
    assign w_par_fail = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Tick counter only runs inside a frame so the first tick is phase-aligned to start detection.
    assign w_tick    = (r_state != c_ST_IDLE) && (r_tick_cnt == c_TICK_MAX);
    assign w_mid     = (r_os_cnt == c_OS_LAST);
    assign rx_busy   = (r_state != c_ST_IDLE);
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_os_clr    = 1'b0;
        w_os_inc    = 1'b0;
        w_shift     = 1'b0;
        w_bit_clr   = 1'b0;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_chk   = 1'b0;
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            c_ST_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = c_ST_START;
                    w_os_clr    = 1'b1;
                end
            end
            c_ST_START: begin
                if (w_tick) begin
                    if (r_os_cnt == c_OS_HALF) begin
                        if (r_rx_s) begin
                            w_state_nxt = c_ST_IDLE;
                        end else begin
                            w_state_nxt = c_ST_DATA;
                            w_os_clr    = 1'b1;
                            w_bit_clr   = 1'b1;
                        end
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
            end
            c_ST_DATA: begin
                if (w_tick) begin
                    if (w_mid) begin
                        w_shift  = 1'b1;
                        w_os_clr = 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = c_ST_AFTER_DATA;
                        end
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            c_ST_PARITY: begin
                if (w_tick) begin
                    if (w_mid) begin
                        w_par_chk   = 1'b1;
                        w_os_clr    = 1'b1;
                        w_state_nxt = c_ST_STOP;
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
            end
`endif
            c_ST_STOP: begin
                if (w_tick) begin
                    if (w_mid) begin
                        if (r_rx_s) begin
                            w_state_nxt = c_ST_IDLE;
                            if (!w_par_fail) begin
                                w_valid_nxt = 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            else begin
                                w_perr_nxt = 1'b1;
                            end
`endif
                        end else begin
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = c_ST_BREAK;
                        end
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
            end
            // Held-low line: stay busy until it idles so a break reports a single frame_err.
            c_ST_BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_tick_cnt   <= '0;
            r_os_cnt     <= '0;
            r_bit_cnt    <= 3'd0;
            r_shreg      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;

            if ((r_state == c_ST_IDLE) || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_os_clr) begin
                r_os_cnt <= '0;
            end else if (w_os_inc) begin
                r_os_cnt <= r_os_cnt + 1'b1;
            end

            if (w_bit_clr) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_shift) begin
                r_shreg <= {r_rx_s, r_shreg[7:1]};
            end

            if (w_valid_nxt) begin
                r_rx_data <= r_shreg;
            end
            r_rx_valid  <= w_valid_nxt;
            r_frame_err <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            if (w_par_chk) begin
                r_par_bad <= (r_rx_s != ((^r_shreg) ^ PARITY_ODD));
            end
            r_parity_err <= w_perr_nxt;
`endif
        end
    end

endmodule
`default_nettype wire
